pc_ctrl: RTL and testbench

- Next-generation program-counter unit for the pipelined MIPS core.
- Replaces a plain enable-gated PC register with a parametrised controller that owns:
  - next-address selection: sequential, branch, jump, exception vector;
  - run / single-step execution modes for the debug unit;
  - HALT freezing;
  - an instruction-fetch counter.
- Sits at the head of the IF stage; drives instruction-memory address and the IF/ID PC+4 field.

---
 rtl/pc_ctrl_pkg.sv | 28 ++
 rtl/pc_ctrl_if.sv | 62 ++++++
 rtl/pc_next_sel.sv | 61 ++++++
 rtl/pc_ctrl.sv | 143 ++++++++++++++
 tb/tb_pc_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pc_ctrl_pkg
//
// Shared constants for the program-counter unit of the pipelined MIPS core:
//   - ADDRWIDTH          : default PC / instruction-address width
//   - EXC_VECTOR_DEFAULT : default exception vector
//   - ST_IDLE .. ST_HALTED : 2-bit controller state encodings (kept as plain
//                            constants so older code can compare against them)
//   - pc_state_is_active() : true when the controller may load the PC
// -----------------------------------------------------------------------------
package pc_ctrl_pkg;

    localparam int          ADDRWIDTH          = 32;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0080;

    typedef logic [1:0] pc_state_t;

    localparam pc_state_t ST_IDLE   = 2'b00;
    localparam pc_state_t ST_RUN    = 2'b01;
    localparam pc_state_t ST_STEP   = 2'b10;
    localparam pc_state_t ST_HALTED = 2'b11;

    // RUN and STEP are the only states in which the PC can move.
    function automatic logic pc_state_is_active(input pc_state_t st);
        return (st == ST_RUN) || (st == ST_STEP);
    endfunction

endpackage : pc_ctrl_pkg

// File: rtl/pc_ctrl_if.sv
// -----------------------------------------------------------------------------
// pc_ctrl_if
//
// Control / address bundle between the PC controller and its neighbours
// (debug unit, hazard unit, decode/execute redirect logic, IF stage).
//
//   Requests into the controller:
//     start_i, mode_step_i, step_i   debug-unit execution control
//     stall_i                        hazard unit hold
//     jump_i / jump_addr_i           jump redirect
//     branch_taken_i / branch_addr_i taken-branch redirect
//     exc_i                          exception request
//     halt_i                         HALT instruction decoded
//   Results out of the controller:
//     pc_o, pc_plus4_o               current PC and sequential successor
//     update_o                       one-cycle pulse after each PC load
//     running_o, halted_o            execution status
//     count_o                        saturating PC-load counter
//
//   modport master : the surrounding core (drives requests)
//   modport slave  : pc_ctrl
// -----------------------------------------------------------------------------
interface pc_ctrl_if
    import pc_ctrl_pkg::*;
#(
    parameter int NB_ADDR  = ADDRWIDTH,
    parameter int NB_COUNT = 32
);

    logic                start_i;
    logic                mode_step_i;
    logic                step_i;
    logic                stall_i;
    logic                jump_i;
    logic [NB_ADDR-1:0]  jump_addr_i;
    logic                branch_taken_i;
    logic [NB_ADDR-1:0]  branch_addr_i;
    logic                exc_i;
    logic                halt_i;

    logic [NB_ADDR-1:0]  pc_o;
    logic [NB_ADDR-1:0]  pc_plus4_o;
    logic                update_o;
    logic                running_o;
    logic                halted_o;
    logic [NB_COUNT-1:0] count_o;

    modport master (
        output start_i, mode_step_i, step_i, stall_i,
               jump_i, jump_addr_i, branch_taken_i, branch_addr_i,
               exc_i, halt_i,
        input  pc_o, pc_plus4_o, update_o, running_o, halted_o, count_o
    );

    modport slave (
        input  start_i, mode_step_i, step_i, stall_i,
               jump_i, jump_addr_i, branch_taken_i, branch_addr_i,
               exc_i, halt_i,
        output pc_o, pc_plus4_o, update_o, running_o, halted_o, count_o
    );

endinterface : pc_ctrl_if

// File: rtl/pc_next_sel.sv
// -----------------------------------------------------------------------------
// pc_next_sel
//
// Purely combinational next-address selector.
//   Priority: exception vector > jump target > branch target > pc + INSTR_BYTES
//   Redirect targets are aligned to INSTR_BYTES by clearing their low bits.
//   The sequential increment wraps modulo 2^NB_ADDR.
//
// Ports:
//   pc_i            current PC
//   exc_i           exception request
//   jump_i          jump request,          jump_addr_i   its target
//   branch_taken_i  taken-branch request,  branch_addr_i its target
//   next_pc_o       selected next PC
//   seq_pc_o        pc_i + INSTR_BYTES (also drives pc_plus4_o upstream)
// -----------------------------------------------------------------------------
module pc_next_sel
    import pc_ctrl_pkg::*;
#(
    parameter int          NB_ADDR     = ADDRWIDTH,
    parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEFAULT,
    parameter int          INSTR_BYTES = 4
) (
    input  logic [NB_ADDR-1:0] pc_i,
    input  logic               exc_i,
    input  logic               jump_i,
    input  logic [NB_ADDR-1:0] jump_addr_i,
    input  logic               branch_taken_i,
    input  logic [NB_ADDR-1:0] branch_addr_i,
    output logic [NB_ADDR-1:0] next_pc_o,
    output logic [NB_ADDR-1:0] seq_pc_o
);

    // Number of low address bits that must be zero for an aligned fetch.
    localparam int ALIGN_BITS = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 0;

    localparam logic [NB_ADDR-1:0] ALIGN_MASK =
        ~((NB_ADDR'(1) << ALIGN_BITS) - NB_ADDR'(1));

    localparam logic [NB_ADDR-1:0] INCREMENT = NB_ADDR'(INSTR_BYTES);

    // The vector is specified as 32 bits; narrower PCs keep the low bits.
    localparam logic [NB_ADDR-1:0] EXC_ADDR = NB_ADDR'(EXC_VECTOR);

    // Natural modulo-2^NB_ADDR addition gives the required wrap-around.
    assign seq_pc_o = pc_i + INCREMENT;

    always_comb begin
        // NOTE: every path through an always_comb must assign its outputs;
        // the leading default guarantees that and so no latch is inferred.
        next_pc_o = seq_pc_o;
        if (exc_i) begin
            next_pc_o = EXC_ADDR & ALIGN_MASK;
        end else if (jump_i) begin
            next_pc_o = jump_addr_i & ALIGN_MASK;
        end else if (branch_taken_i) begin
            next_pc_o = branch_addr_i & ALIGN_MASK;
        end
    end

endmodule : pc_next_sel

// File: rtl/pc_ctrl.sv
// -----------------------------------------------------------------------------
// pc_ctrl
//
// Program-counter controller at the head of the IF stage. Owns the PC
// register, the IDLE/RUN/STEP/HALTED execution FSM, and a saturating
// counter of PC loads. All registers update on the falling edge of clock_i;
// reset_i is synchronous, active-high and overrides every state.
//
// Ports:
//   clock_i   core clock (registers update on its falling edge)
//   reset_i   synchronous active-high reset
//   bus       pc_ctrl_if.slave: requests in, PC / status out
//
// Load rules:
//   RUN  : load enable = !stall_i
//   STEP : load enable = step_i & !stall_i (a step during a stall is lost)
//   exc_i in RUN/STEP always loads the exception vector, even when stalled
//   or not stepping, and beats a simultaneous halt_i.
//   halt_i with load enable high moves to HALTED without loading the PC.
// -----------------------------------------------------------------------------
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int                 NB_ADDR     = ADDRWIDTH,
    parameter int                 NB_COUNT    = 32,
    parameter logic [NB_ADDR-1:0] RESET_ADDR  = '0,
    parameter logic [31:0]        EXC_VECTOR  = EXC_VECTOR_DEFAULT,
    parameter int                 INSTR_BYTES = 4
) (
    input  logic      clock_i,
    input  logic      reset_i,
    pc_ctrl_if.slave  bus
);

    pc_state_t           state_q,  state_d;
    logic [NB_ADDR-1:0]  pc_q,     pc_d;
    logic [NB_COUNT-1:0] count_q,  count_d;
    logic                update_q, update_d;

    logic [NB_ADDR-1:0]  next_pc;
    logic [NB_ADDR-1:0]  seq_pc;
    logic                load_en;
    logic                do_load;

    // -------------------------------------------------------------------------
    // Next-address selection
    // -------------------------------------------------------------------------
    pc_next_sel #(
        .NB_ADDR     (NB_ADDR),
        .EXC_VECTOR  (EXC_VECTOR),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_next_sel (
        .pc_i           (pc_q),
        .exc_i          (bus.exc_i),
        .jump_i         (bus.jump_i),
        .jump_addr_i    (bus.jump_addr_i),
        .branch_taken_i (bus.branch_taken_i),
        .branch_addr_i  (bus.branch_addr_i),
        .next_pc_o      (next_pc),
        .seq_pc_o       (seq_pc)
    );

    // -------------------------------------------------------------------------
    // FSM, PC and counter next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        update_d = 1'b0;
        load_en  = 1'b0;
        do_load  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Hold the reset address; only start_i is looked at here.
                pc_d = RESET_ADDR;
                if (bus.start_i) begin
                    state_d = bus.mode_step_i ? ST_STEP : ST_RUN;
                end
            end

            ST_RUN, ST_STEP: begin
                load_en = !bus.stall_i && ((state_q == ST_RUN) || bus.step_i);
                if (bus.exc_i) begin
                    // Exceptions ignore stall/step and suppress halt.
                    do_load = 1'b1;
                end else if (load_en) begin
                    if (bus.halt_i) begin
                        state_d = ST_HALTED;
                    end else begin
                        do_load = 1'b1;
                    end
                end
            end

            ST_HALTED: begin
                // Frozen until reset_i; all defaults already hold state.
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_load) begin
            pc_d     = next_pc;
            update_d = 1'b1;
            // Saturate rather than wrap so a long run never reads as short.
            count_d  = (count_q == '1) ? count_q : count_q + NB_COUNT'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Registers (falling edge, synchronous reset)
    // -------------------------------------------------------------------------
    always_ff @(negedge clock_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset_i) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_ADDR;
            count_q  <= '0;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            update_q <= update_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.pc_o       = pc_q;
    assign bus.pc_plus4_o = seq_pc;
    assign bus.update_o   = update_q;
    assign bus.running_o  = pc_state_is_active(state_q);
    assign bus.halted_o   = (state_q == ST_HALTED);
    assign bus.count_o    = count_q;

endmodule : pc_ctrl

// File: tb/tb_pc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_ctrl
//
// Directed bench for pc_ctrl. The DUT updates on the falling edge, so the
// bench drives inputs and samples outputs right after each rising edge.
// A second instance with a 4-bit counter covers counter saturation.
// -----------------------------------------------------------------------------
module tb_pc_ctrl;

    logic clk;
    logic rst;

    int tests_run;
    int tests_failed;

    pc_ctrl_if #(.NB_ADDR(32), .NB_COUNT(32)) bus  ();
    pc_ctrl_if #(.NB_ADDR(32), .NB_COUNT(4))  bus4 ();

    pc_ctrl #(
        .NB_ADDR     (32),
        .NB_COUNT    (32),
        .RESET_ADDR  (32'h0),
        .EXC_VECTOR  (32'h0000_0080),
        .INSTR_BYTES (4)
    ) u_dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    pc_ctrl #(
        .NB_ADDR     (32),
        .NB_COUNT    (4),
        .RESET_ADDR  (32'h0),
        .EXC_VECTOR  (32'h0000_0080),
        .INSTR_BYTES (4)
    ) u_dut4 (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One full clock: passes exactly one falling (active) edge and returns
    // just after the following rising edge, where outputs are stable.
    task automatic cycle();
        @(posedge clk);
    endtask

    task automatic clear_inputs();
        bus.start_i = 0;  bus.mode_step_i = 0; bus.step_i = 0; bus.stall_i = 0;
        bus.jump_i = 0;   bus.jump_addr_i = '0; bus.branch_taken_i = 0;
        bus.branch_addr_i = '0; bus.exc_i = 0; bus.halt_i = 0;
        bus4.start_i = 0; bus4.mode_step_i = 0; bus4.step_i = 0; bus4.stall_i = 0;
        bus4.jump_i = 0;  bus4.jump_addr_i = '0; bus4.branch_taken_i = 0;
        bus4.branch_addr_i = '0; bus4.exc_i = 0; bus4.halt_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    // Reset, then start in the requested mode (one edge, PC stays at 0).
    task automatic reset_and_start(input logic step_mode);
        do_reset();
        bus.start_i = 1'b1;
        bus.mode_step_i = step_mode;
        cycle();
        bus.start_i = 1'b0;
        bus.mode_step_i = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({bus.pc_o, bus.count_o, bus.update_o, bus.running_o, bus.halted_o}
            !== {32'h0, 32'd0, 1'b0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_state: pc=%h cnt=%0d upd=%b run=%b hlt=%b, expected pc=0 cnt=0 upd=0 run=0 hlt=0",
                     bus.pc_o, bus.count_o, bus.update_o, bus.running_o, bus.halted_o);
        end
        tests_run++;
        if (bus.pc_plus4_o !== 32'h4) begin
            tests_failed++;
            $display("FAIL reset_pc_plus4: got %h expected 00000004", bus.pc_plus4_o);
        end
        // IDLE ignores redirects and exceptions.
        bus.jump_i = 1; bus.jump_addr_i = 32'h100; bus.exc_i = 1;
        cycle();
        clear_inputs();
        tests_run++;
        if ({bus.pc_o, bus.count_o, bus.running_o} !== {32'h0, 32'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL idle_ignores: pc=%h cnt=%0d run=%b, expected pc=0 cnt=0 run=0",
                     bus.pc_o, bus.count_o, bus.running_o);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_run_seq();
        reset_and_start(1'b0);
        tests_run++;
        if ({bus.pc_o, bus.running_o, bus.update_o} !== {32'h0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL run_start: pc=%h run=%b upd=%b, expected pc=0 run=1 upd=0",
                     bus.pc_o, bus.running_o, bus.update_o);
        end
        for (int i = 1; i <= 5; i++) begin
            cycle();
            tests_run++;
            if ({bus.pc_o, bus.count_o, bus.update_o} !== {32'(4 * i), 32'(i), 1'b1}) begin
                tests_failed++;
                $display("FAIL run_seq[%0d]: pc=%h cnt=%0d upd=%b, expected pc=%h cnt=%0d upd=1",
                         i, bus.pc_o, bus.count_o, bus.update_o, 32'(4 * i), i);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_stall();
        reset_and_start(1'b0);
        cycle();
        cycle();                        // pc = 8, count = 2
        bus.stall_i = 1'b1;
        bus.halt_i  = 1'b1;             // not enabled while stalled: ignored
        for (int i = 0; i < 3; i++) begin
            cycle();
            bus.halt_i = 1'b0;
            tests_run++;
            if ({bus.pc_o, bus.count_o, bus.update_o, bus.halted_o}
                !== {32'h8, 32'd2, 1'b0, 1'b0}) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: pc=%h cnt=%0d upd=%b hlt=%b, expected pc=8 cnt=2 upd=0 hlt=0",
                         i, bus.pc_o, bus.count_o, bus.update_o, bus.halted_o);
            end
        end
        bus.stall_i = 1'b0;
        cycle();
        tests_run++;
        if ({bus.pc_o, bus.count_o, bus.update_o} !== {32'hC, 32'd3, 1'b1}) begin
            tests_failed++;
            $display("FAIL stall_resume: pc=%h cnt=%0d upd=%b, expected pc=c cnt=3 upd=1",
                     bus.pc_o, bus.count_o, bus.update_o);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_redirect();
        reset_and_start(1'b0);
        bus.jump_i = 1; bus.jump_addr_i = 32'h40;
        bus.branch_taken_i = 1; bus.branch_addr_i = 32'h20;
        cycle();
        tests_run++;
        if ({bus.pc_o, bus.count_o} !== {32'h40, 32'd1}) begin
            tests_failed++;
            $display("FAIL jump_over_branch: pc=%h cnt=%0d, expected pc=40 cnt=1",
                     bus.pc_o, bus.count_o);
        end
        bus.jump_i = 0; bus.branch_addr_i = 32'h23;
        cycle();
        tests_run++;
        if (bus.pc_o !== 32'h20) begin
            tests_failed++;
            $display("FAIL branch_aligned: pc=%h, expected 00000020", bus.pc_o);
        end
        bus.branch_taken_i = 0;
        cycle();
        tests_run++;
        if ({bus.pc_o, bus.pc_plus4_o, bus.count_o} !== {32'h24, 32'h28, 32'd3}) begin
            tests_failed++;
            $display("FAIL after_branch: pc=%h pc4=%h cnt=%0d, expected pc=24 pc4=28 cnt=3",
                     bus.pc_o, bus.pc_plus4_o, bus.count_o);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_step();
        logic [31:0] exp_pc;
        logic        exp_upd;
        reset_and_start(1'b1);
        for (int c = 1; c <= 8; c++) begin
            bus.step_i  = (c == 2) || (c == 4) || (c == 6);
            bus.stall_i = (c == 4);
            cycle();
            exp_pc  = ((c >= 2) ? 32'h4 : 32'h0) + ((c >= 6) ? 32'h4 : 32'h0);
            exp_upd = (c == 2) || (c == 6);
            tests_run++;
            if ({bus.pc_o, bus.update_o} !== {exp_pc, exp_upd}) begin
                tests_failed++;
                $display("FAIL step_cycle[%0d]: pc=%h upd=%b, expected pc=%h upd=%b",
                         c, bus.pc_o, bus.update_o, exp_pc, exp_upd);
            end
        end
        clear_inputs();
        tests_run++;
        if ({bus.pc_o, bus.count_o, bus.running_o} !== {32'h8, 32'd2, 1'b1}) begin
            tests_failed++;
            $display("FAIL step_total: pc=%h cnt=%0d run=%b, expected pc=8 cnt=2 run=1",
                     bus.pc_o, bus.count_o, bus.running_o);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_halt();
        int bad;
        reset_and_start(1'b0);
        for (int i = 0; i < 4; i++) cycle();    // pc = 0x10, count = 4
        bus.halt_i = 1'b1;
        cycle();
        bus.halt_i = 1'b0;
        tests_run++;
        if ({bus.pc_o, bus.count_o, bus.halted_o, bus.running_o, bus.update_o}
            !== {32'h10, 32'd4, 1'b1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL halt_enter: pc=%h cnt=%0d hlt=%b run=%b upd=%b, expected pc=10 cnt=4 hlt=1 run=0 upd=0",
                     bus.pc_o, bus.count_o, bus.halted_o, bus.running_o, bus.update_o);
        end
        bad = 0;
        bus.step_i = 1; bus.start_i = 1; bus.exc_i = 1; bus.mode_step_i = 1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            tests_run++;
            if ({bus.pc_o, bus.count_o, bus.halted_o} !== {32'h10, 32'd4, 1'b1}) begin
                tests_failed++;
                $display("FAIL halt_frozen[%0d]: pc=%h cnt=%0d hlt=%b, expected pc=10 cnt=4 hlt=1",
                         i, bus.pc_o, bus.count_o, bus.halted_o);
            end
        end
        // Reset wins even with start_i still asserted.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        clear_inputs();
        tests_run++;
        if ({bus.pc_o, bus.count_o, bus.halted_o, bus.running_o}
            !== {32'h0, 32'd0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL halt_reset: pc=%h cnt=%0d hlt=%b run=%b, expected pc=0 cnt=0 hlt=0 run=0",
                     bus.pc_o, bus.count_o, bus.halted_o, bus.running_o);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_exception();
        reset_and_start(1'b0);
        cycle();                                 // pc = 4, count = 1
        bus.stall_i = 1; bus.exc_i = 1;
        cycle();
        clear_inputs();
        tests_run++;
        if ({bus.pc_o, bus.count_o, bus.update_o} !== {32'h80, 32'd2, 1'b1}) begin
            tests_failed++;
            $display("FAIL exc_during_stall: pc=%h cnt=%0d upd=%b, expected pc=80 cnt=2 upd=1",
                     bus.pc_o, bus.count_o, bus.update_o);
        end

        reset_and_start(1'b0);
        bus.exc_i = 1; bus.halt_i = 1; bus.jump_i = 1; bus.jump_addr_i = 32'h200;
        cycle();
        clear_inputs();
        tests_run++;
        if ({bus.pc_o, bus.halted_o, bus.running_o, bus.count_o}
            !== {32'h80, 1'b0, 1'b1, 32'd1}) begin
            tests_failed++;
            $display("FAIL exc_with_halt: pc=%h hlt=%b run=%b cnt=%0d, expected pc=80 hlt=0 run=1 cnt=1",
                     bus.pc_o, bus.halted_o, bus.running_o, bus.count_o);
        end

        reset_and_start(1'b1);
        bus.exc_i = 1;                           // no step_i
        cycle();
        clear_inputs();
        tests_run++;
        if ({bus.pc_o, bus.count_o, bus.running_o} !== {32'h80, 32'd1, 1'b1}) begin
            tests_failed++;
            $display("FAIL exc_in_step: pc=%h cnt=%0d run=%b, expected pc=80 cnt=1 run=1",
                     bus.pc_o, bus.count_o, bus.running_o);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_wrap();
        reset_and_start(1'b0);
        bus.jump_i = 1; bus.jump_addr_i = 32'hFFFF_FFFE;   // aligns to ...FC
        cycle();
        bus.jump_i = 0;
        tests_run++;
        if ({bus.pc_o, bus.pc_plus4_o} !== {32'hFFFF_FFFC, 32'h0}) begin
            tests_failed++;
            $display("FAIL wrap_top: pc=%h pc4=%h, expected pc=fffffffc pc4=00000000",
                     bus.pc_o, bus.pc_plus4_o);
        end
        cycle();
        tests_run++;
        if ({bus.pc_o, bus.count_o} !== {32'h0, 32'd2}) begin
            tests_failed++;
            $display("FAIL wrap_zero: pc=%h cnt=%0d, expected pc=0 cnt=2",
                     bus.pc_o, bus.count_o);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_count_sat();
        logic [3:0] exp_cnt;
        do_reset();
        bus4.start_i = 1'b1;
        cycle();
        bus4.start_i = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (k == 14 || k == 15 || k == 16 || k == 20) begin
                exp_cnt = (k < 15) ? 4'(k) : 4'd15;
                tests_run++;
                if ({bus4.count_o, bus4.pc_o} !== {exp_cnt, 32'(4 * k)}) begin
                    tests_failed++;
                    $display("FAIL count_sat[%0d]: cnt=%0d pc=%h, expected cnt=%0d pc=%h",
                             k, bus4.count_o, bus4.pc_o, exp_cnt, 32'(4 * k));
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        clear_inputs();

        test_reset();
        test_run_seq();
        test_stall();
        test_redirect();
        test_step();
        test_halt();
        test_exception();
        test_wrap();
        test_count_sat();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_pc_ctrl
